// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache FSM state, frame layout and tag helper.
package cpu_types_pkg;

    localparam int ICACHE_FRAMES_DEF = 16;
    localparam int ICACHE_IDX_W_DEF  = $clog2(ICACHE_FRAMES_DEF);
    localparam int ICACHE_TAG_W_DEF  = 30 - ICACHE_IDX_W_DEF;
    // Widest possible tag (FRAMES=2); narrower tags are stored zero-extended.
    localparam int ICACHE_TAG_W_MAX  = 29;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_W_MAX-1:0] tag;
        logic [31:0]                 data;
    } icache_frame_t;

    function automatic logic [ICACHE_TAG_W_MAX-1:0] icache_tag(input logic [31:0] addr,
                                                               input int          idx_w);
        return ICACHE_TAG_W_MAX'(addr >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one combinational read port, one synchronous
// write port and a single-cycle clear of every valid bit.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int FRAMES = ICACHE_FRAMES_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [$clog2(FRAMES)-1:0]   ridx,
    output icache_frame_t               rframe,
    input  logic                        we,
    input  logic [$clog2(FRAMES)-1:0]   widx,
    input  logic [ICACHE_TAG_W_MAX-1:0] wtag,
    input  logic [31:0]                 wdata,
    input  logic                        clear
);

    logic [FRAMES-1:0]           valid;
    logic [ICACHE_TAG_W_MAX-1:0] tags  [FRAMES];
    logic [31:0]                 words [FRAMES];

    // A clear in the same cycle as a write wins, so that fill is never marked valid.
    always_ff @(posedge CLK) begin
        if (RST || clear)
            valid <= '0;
        else if (we)
            valid[widx] <= 1'b1;
    end

    // NOTE: tag and data storage is not reset; the valid bit alone qualifies a frame.
    always_ff @(posedge CLK) begin
        if (we) begin
            tags[widx]  <= wtag;
            words[widx] <= wdata;
        end
    end

    always_comb begin
        rframe.valid = valid[ridx];
        rframe.tag   = tags[ridx];
        rframe.data  = words[ridx];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-latency hits, one-word miss fills,
// saturating hit/miss counters and a single-cycle invalidate-all.
module icache
    import cpu_types_pkg::*;
#(
    parameter int FRAMES = ICACHE_FRAMES_DEF,
    parameter int CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(FRAMES);

    icache_state_t               state, next_state;
    logic [31:0]                 miss_addr;
    logic [IDX_W-1:0]            idx, fill_idx;
    logic [ICACHE_TAG_W_MAX-1:0] tag, fill_tag;
    icache_frame_t               rframe;
    logic                        hit, miss_start, fill;

    assign idx      = imemaddr[IDX_W+1:2];
    assign tag      = icache_tag(imemaddr, IDX_W);
    assign fill_idx = miss_addr[IDX_W+1:2];
    assign fill_tag = icache_tag(miss_addr, IDX_W);

    assign hit        = !RST && (state == IDLE) && imemREN && rframe.valid && (rframe.tag == tag);
    assign miss_start = (state == IDLE) && imemREN && !hit;
    // A fill interrupted by reset must not leave a frame behind.
    assign fill       = (state == FETCH) && !iwait && !RST;

    icache_frame_array #(.FRAMES(FRAMES)) u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .ridx   (idx),
        .rframe (rframe),
        .we     (fill),
        .widx   (fill_idx),
        .wtag   (fill_tag),
        .wdata  (iload),
        .clear  (flush)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (miss_start) next_state = FETCH;
            FETCH:   if (!iwait)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ihit     = hit;
        imemload = hit ? rframe.data : '0;
        iREN     = (state == FETCH);
        iaddr    = (state == FETCH) ? miss_addr : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            miss_addr <= '0;
        else if (miss_start)
            miss_addr <= {imemaddr[31:2], 2'b00};
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (miss_start && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end

endmodule
